// File: rtl/mem_bank_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bank_responder_pkg                                                     |
// | Field widths, packet layout macros and FSM encoding for the memory bank.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`ifndef MEM_BANK_RESPONDER_PKG_SV
`define MEM_BANK_RESPONDER_PKG_SV

// Field macros resolve width names in the caller's scope, so a parameterised
// top slices with its own (possibly overridden) widths.
`define PKT_CORE_ID(p)    p[CORE_ID_BITS-1:0]
`define PKT_DATA(p)       p[CORE_ID_BITS +: DATA_WIDTH]
`define PKT_PRIORITY(p)   p[CORE_ID_BITS+DATA_WIDTH +: PRI_BITS]
`define PKT_LOCAL_ADDR(p) p[CORE_ID_BITS+DATA_WIDTH+PRI_BITS +: LOCAL_ADDR_BITS]
`define PKT_MODULE_ID(p)  p[CORE_ID_BITS+DATA_WIDTH+PRI_BITS+LOCAL_ADDR_BITS +: MOD_ID_BITS]
`define PKT_RW(p)         p[PACKET_W-1]
`define BACK_PKT_SUC(b)   b[BACK_PACKET_W-1]
`define MAKE_PACKET(rw, mod, addr, pri, data, core) {rw, mod, addr, pri, data, core}
`define MAKE_BACK_PACKET(suc, rw, data, core)       {suc, rw, data, core}

package mem_bank_responder_pkg;

    localparam int PRI_BITS        = 2;
    localparam int MOD_ID_BITS     = 2;
    localparam int LOCAL_ADDR_BITS = 7;
    localparam int DATA_WIDTH      = 32;
    localparam int CORE_ID_BITS    = 3;
    localparam int PACKET_W        = 1 + MOD_ID_BITS + LOCAL_ADDR_BITS + PRI_BITS
                                     + DATA_WIDTH + CORE_ID_BITS;
    localparam int BACK_PACKET_W   = 2 + DATA_WIDTH + CORE_ID_BITS;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

`endif
`default_nettype wire

// File: rtl/mem_bank_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bank_arbiter2                                                          |
// | Two-port priority arbiter with round-robin tie-break (pointer held above). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_bank_arbiter2
    import mem_bank_responder_pkg::*;
#(
    parameter int PRI_BITS = 2
) (
    input  logic [1:0]          i_elig,
    input  logic [PRI_BITS-1:0] i_pri0,
    input  logic [PRI_BITS-1:0] i_pri1,
    input  logic                i_rr,
    output logic [1:0]          o_grant,
    output logic                o_tie
);

    always_comb begin
        o_grant = 2'b00;
        o_tie   = 1'b0;
        case (i_elig)
            2'b01: o_grant = 2'b01;
            2'b10: o_grant = 2'b10;
            2'b11: begin
                if (i_pri0 > i_pri1) begin
                    o_grant = 2'b01;
                end else if (i_pri1 > i_pri0) begin
                    o_grant = 2'b10;
                end else begin
                    o_tie   = 1'b1;
                    o_grant = i_rr ? 2'b10 : 2'b01;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_bank_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_bank_responder                                                         |
// | Two-port butterfly memory endpoint: arbitrate, access bank, return ACK/NACK|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_bank_responder
    import mem_bank_responder_pkg::*;
#(
    parameter int MY_MOD_ID       = 0,
    parameter int PRI_BITS        = 2,
    parameter int MOD_ID_BITS     = 2,
    parameter int LOCAL_ADDR_BITS = 7,
    parameter int DATA_WIDTH      = 32,
    parameter int CORE_ID_BITS    = 3,
    parameter int CNT_W           = 16,
    localparam int PACKET_W       = 1 + MOD_ID_BITS + LOCAL_ADDR_BITS + PRI_BITS
                                    + DATA_WIDTH + CORE_ID_BITS,
    localparam int BACK_PACKET_W  = 2 + DATA_WIDTH + CORE_ID_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 valid_in,
    input  logic [2*PACKET_W-1:0]      in_flat,
    output logic [1:0]                 valid_back_out,
    output logic [2*BACK_PACKET_W-1:0] out_flat,
    output logic                       ready,
    output logic                       collision,
    output logic [CNT_W-1:0]           collision_count,
    output logic [CNT_W-1:0]           misroute_count
);

    localparam int DEPTH = 1 << LOCAL_ADDR_BITS;
    localparam int CW1   = CNT_W + 1;

    state_e                     state_q, state_d;
    logic [LOCAL_ADDR_BITS-1:0] clear_addr_q, clear_addr_d;
    logic                       rr_q, rr_d;

    logic [1:0]                 s1_valid_q, s1_valid_d, s1_win_q, s1_win_d;
    logic [1:0]                 s1_lose_q, s1_lose_d, s1_mis_q, s1_mis_d;
    logic                       s1_rw_q   [2], s1_rw_d   [2];
    logic [LOCAL_ADDR_BITS-1:0] s1_addr_q [2], s1_addr_d [2];
    logic [DATA_WIDTH-1:0]      s1_data_q [2], s1_data_d [2];
    logic [CORE_ID_BITS-1:0]    s1_core_q [2], s1_core_d [2];

    logic [1:0]                 valid_back_q, valid_back_d;
    logic [2*BACK_PACKET_W-1:0] out_flat_q, out_flat_d;
    logic                       collision_q, collision_d;
    logic [CNT_W-1:0]           collision_count_q, collision_count_d;
    logic [CNT_W-1:0]           misroute_count_q, misroute_count_d;

    logic [DATA_WIDTH-1:0]      mem_q [DEPTH];

    logic                       w_run, w_tie, w_acc_port, w_mem_we;
    logic [PACKET_W-1:0]        w_req [2];
    logic [1:0]                 w_mod_ok, w_elig, w_grant;
    logic [LOCAL_ADDR_BITS-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0]      w_mem_wdata, w_rdata;
    logic [DATA_WIDTH-1:0]      w_bdata [2];
    logic [CNT_W:0]             w_coll_sum, w_mis_sum;

    always_comb begin
        w_run = (state_q == ST_RUN);
        for (int p = 0; p < 2; p++) begin
            w_req[p]    = in_flat[p*PACKET_W +: PACKET_W];
            w_mod_ok[p] = (`PKT_MODULE_ID(w_req[p]) == MOD_ID_BITS'(MY_MOD_ID));
            w_elig[p]   = w_run & valid_in[p] & w_mod_ok[p];
        end
    end

    mem_bank_arbiter2 #(
        .PRI_BITS (PRI_BITS)
    ) u_arb (
        .i_elig  (w_elig),
        .i_pri0  (`PKT_PRIORITY(w_req[0])),
        .i_pri1  (`PKT_PRIORITY(w_req[1])),
        .i_rr    (rr_q),
        .o_grant (w_grant),
        .o_tie   (w_tie)
    );

    always_comb begin
        state_d      = state_q;
        clear_addr_d = clear_addr_q;
        case (state_q)
            ST_CLEAR: begin
                clear_addr_d = clear_addr_q + 1'b1;
                if (&clear_addr_q) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = state_q;
        endcase
    end

    // Stage 1: latch the grant decision and the fields the bank needs.
    always_comb begin
        rr_d       = w_tie ? ~rr_q : rr_q;
        s1_valid_d = valid_in;
        s1_win_d   = w_grant;
        s1_lose_d  = w_elig & ~w_grant;
        s1_mis_d   = {2{w_run}} & valid_in & ~w_mod_ok;
        for (int p = 0; p < 2; p++) begin
            s1_rw_d[p]   = `PKT_RW(w_req[p]);
            s1_addr_d[p] = `PKT_LOCAL_ADDR(w_req[p]);
            s1_data_d[p] = `PKT_DATA(w_req[p]);
            s1_core_d[p] = `PKT_CORE_ID(w_req[p]);
        end
    end

    // Stage 2: at most one winner, so the bank port follows whichever won.
    always_comb begin
        w_acc_port = s1_win_q[1];
        w_rdata    = mem_q[s1_addr_q[w_acc_port]];
        if (state_q == ST_CLEAR) begin
            w_mem_we    = ~rst;
            w_mem_addr  = clear_addr_q;
            w_mem_wdata = '0;
        end else begin
            w_mem_we    = ~rst & (|s1_win_q) & s1_rw_q[w_acc_port];
            w_mem_addr  = s1_addr_q[w_acc_port];
            w_mem_wdata = s1_data_q[w_acc_port];
        end

        valid_back_d = s1_valid_q;
        out_flat_d   = '0;
        for (int p = 0; p < 2; p++) begin
            w_bdata[p] = '0;
            if (s1_win_q[p]) begin
                w_bdata[p] = s1_rw_q[p] ? s1_data_q[p] : w_rdata;
            end
            if (s1_valid_q[p]) begin
                out_flat_d[p*BACK_PACKET_W +: BACK_PACKET_W] =
                    `MAKE_BACK_PACKET(s1_win_q[p], s1_rw_q[p], w_bdata[p], s1_core_q[p]);
            end
        end

        collision_d       = |s1_lose_q;
        w_coll_sum        = {1'b0, collision_count_q} + CW1'(|s1_lose_q);
        w_mis_sum         = {1'b0, misroute_count_q} + CW1'(s1_mis_q[0]) + CW1'(s1_mis_q[1]);
        collision_count_d = w_coll_sum[CNT_W] ? {CNT_W{1'b1}} : w_coll_sum[CNT_W-1:0];
        misroute_count_d  = w_mis_sum[CNT_W]  ? {CNT_W{1'b1}} : w_mis_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_CLEAR;
            clear_addr_q      <= '0;
            rr_q              <= 1'b0;
            s1_valid_q        <= '0;
            s1_win_q          <= '0;
            s1_lose_q         <= '0;
            s1_mis_q          <= '0;
            for (int p = 0; p < 2; p++) begin
                s1_rw_q[p]   <= 1'b0;
                s1_addr_q[p] <= '0;
                s1_data_q[p] <= '0;
                s1_core_q[p] <= '0;
            end
            valid_back_q      <= '0;
            out_flat_q        <= '0;
            collision_q       <= 1'b0;
            collision_count_q <= '0;
            misroute_count_q  <= '0;
        end else begin
            state_q           <= state_d;
            clear_addr_q      <= clear_addr_d;
            rr_q              <= rr_d;
            s1_valid_q        <= s1_valid_d;
            s1_win_q          <= s1_win_d;
            s1_lose_q         <= s1_lose_d;
            s1_mis_q          <= s1_mis_d;
            for (int p = 0; p < 2; p++) begin
                s1_rw_q[p]   <= s1_rw_d[p];
                s1_addr_q[p] <= s1_addr_d[p];
                s1_data_q[p] <= s1_data_d[p];
                s1_core_q[p] <= s1_core_d[p];
            end
            valid_back_q      <= valid_back_d;
            out_flat_q        <= out_flat_d;
            collision_q       <= collision_d;
            collision_count_q <= collision_count_d;
            misroute_count_q  <= misroute_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_addr] <= w_mem_wdata;
        end
    end

    assign valid_back_out  = valid_back_q;
    assign out_flat        = out_flat_q;
    assign ready           = (state_q == ST_RUN);
    assign collision       = collision_q;
    assign collision_count = collision_count_q;
    assign misroute_count  = misroute_count_q;

endmodule
`default_nettype wire
